// File: rtl/multicore_pkg.sv
// Shared multicore types: system op encoding, data width, trap causes and scheduler FSM states.
// The trap-related items are used only when SYSOP_TRAP_EN is defined.
package multicore_pkg;

  localparam int DATA_SIZE = 32;

  typedef enum logic [2:0] {
    RDCYCLE    = 3'd0,
    RDCYCLEH   = 3'd1,
    RDTIME     = 3'd2,
    RDTIMEH    = 3'd3,
    RDINSTRET  = 3'd4,
    RDINSTRETH = 3'd5,
    SCALL      = 3'd6,
    SBREAK     = 3'd7
  } t_sysop;

  typedef enum logic {
    TRAP_SCALL  = 1'b0,
    TRAP_SBREAK = 1'b1
  } t_trap_cause;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_TRAP  = 2'd3
  } t_sysop_sched_state;

  function automatic logic is_trap_op(input t_sysop op);
    return (op == SCALL) || (op == SBREAK);
  endfunction

endpackage

// File: rtl/sysop_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx
);

  logic            found;
  int              j;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    j            = 0;
    idx          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/sysop_scheduler.sv
// Shares one system execute unit among NUM_REQ hardware threads, one op in flight at a time.
// SYSOP_TRAP_EN routes SCALL/SBREAK through a trap handshake instead of the unit.
module sysop_scheduler
  import multicore_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_aclk,
  input  logic                          i_areset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  t_sysop [NUM_REQ-1:0]          i_req_op,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output t_sysop                        o_unit_op,
  input  logic [DATA_SIZE-1:0]          i_unit_result,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_SIZE-1:0]          o_rsp_data,
  input  logic [NUM_REQ-1:0]            i_rsp_ready,
`ifdef SYSOP_TRAP_EN
  output logic                          o_trap_valid,
  output logic [REQ_ID_W-1:0]           o_trap_id,
  output t_trap_cause                   o_trap_cause,
  input  logic                          i_trap_ack,
`endif
  output t_sysop_sched_state            o_state
);

  // Handshakes: a request transfers when i_req_valid[i] & o_req_ready[i] at a rising edge;
  // a response transfers when o_rsp_valid[g] & i_rsp_ready[g]. Valid never drops before transfer.

  t_sysop_sched_state    state_q;
  logic [REQ_ID_W-1:0]   ptr_q;
  logic [REQ_ID_W-1:0]   grant_q;
  t_sysop                op_q;
  t_sysop                unit_op_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_SIZE-1:0]  rsp_data_q;
  logic [NUM_REQ-1:0]    arb_onehot;
  logic [REQ_ID_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  handshake;
  t_sysop                req_op_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (i_req_valid),
    .ptr          (ptr_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  // Ready is gated by reset so every output reads zero while reset is held.
  assign req_ready  = (state_q == S_IDLE && !i_areset) ? arb_onehot : '0;
  assign handshake  = |(i_req_valid & req_ready);
  assign req_op_sel = i_req_op[arb_idx];

`ifdef SYSOP_TRAP_EN
  logic                  trap_valid_q;
  logic [REQ_ID_W-1:0]   trap_id_q;
  t_trap_cause           trap_cause_q;
`endif

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      op_q         <= RDCYCLE;
      unit_op_q    <= RDCYCLE;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
`ifdef SYSOP_TRAP_EN
      trap_valid_q <= 1'b0;
      trap_id_q    <= '0;
      trap_cause_q <= TRAP_SCALL;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            grant_q <= arb_idx;
            op_q    <= req_op_sel;
            ptr_q   <= (arb_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`ifdef SYSOP_TRAP_EN
            if (is_trap_op(req_op_sel)) begin
              state_q      <= S_TRAP;
              trap_valid_q <= 1'b1;
              trap_id_q    <= arb_idx;
              trap_cause_q <= (req_op_sel == SCALL) ? TRAP_SCALL : TRAP_SBREAK;
            end else begin
              state_q   <= S_ISSUE;
              unit_op_q <= req_op_sel;
            end
`else
            state_q   <= S_ISSUE;
            unit_op_q <= req_op_sel;
`endif
          end
        end
        S_ISSUE: begin
          // Trap ops never carry the unit's result, which may be undefined for them.
          rsp_data_q  <= is_trap_op(op_q) ? '0 : i_unit_result;
          rsp_valid_q <= NUM_REQ'(1) << grant_q;
          unit_op_q   <= RDCYCLE;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            state_q     <= S_IDLE;
          end
        end
`ifdef SYSOP_TRAP_EN
        S_TRAP: begin
          if (i_trap_ack) begin
            trap_valid_q <= 1'b0;
            trap_id_q    <= '0;
            trap_cause_q <= TRAP_SCALL;
            rsp_valid_q  <= NUM_REQ'(1) << grant_q;
            rsp_data_q   <= '0;
            state_q      <= S_RESP;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = req_ready;
  assign o_unit_op   = unit_op_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_state     = state_q;

`ifdef SYSOP_TRAP_EN
  assign o_trap_valid = trap_valid_q;
  assign o_trap_id    = trap_id_q;
  assign o_trap_cause = trap_cause_q;
`endif

endmodule

// File: tb/tb_sysop_scheduler.sv
// Directed bench for sysop_scheduler: reset, single op latency, round robin, response hold,
// trap-op handling (SYSOP_TRAP_EN selects trap or pass-through checks) and mid-op reset.
module tb_sysop_scheduler;
  import multicore_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  t_sysop [NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   req_ready;
  t_sysop               unit_op;
  logic [DATA_SIZE-1:0] unit_result;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [DATA_SIZE-1:0] rsp_data;
  logic [NUM_REQ-1:0]   rsp_ready;
  t_sysop_sched_state   state;
`ifdef SYSOP_TRAP_EN
  logic                 trap_valid;
  logic [ID_W-1:0]      trap_id;
  t_trap_cause          trap_cause;
  logic                 trap_ack;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DATA_SIZE-1:0] exp_q[$];

  sysop_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_req_valid   (req_valid),
    .i_req_op      (req_op),
    .o_req_ready   (req_ready),
    .o_unit_op     (unit_op),
    .i_unit_result (unit_result),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_data    (rsp_data),
    .i_rsp_ready   (rsp_ready),
`ifdef SYSOP_TRAP_EN
    .o_trap_valid  (trap_valid),
    .o_trap_id     (trap_id),
    .o_trap_cause  (trap_cause),
    .i_trap_ack    (trap_ack),
`endif
    .o_state       (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change at posedge+1, outputs are sampled at posedge+2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    req_valid   = '0;
    rsp_ready   = '0;
    unit_result = '0;
`ifdef SYSOP_TRAP_EN
    trap_ack    = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) req_op[i] = RDCYCLE;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // driver: one complete op for requester idx, immediate response acceptance
  task automatic run_op(input int idx, input t_sysop op, input logic [DATA_SIZE-1:0] res,
                        input logic [DATA_SIZE-1:0] exp_data);
    logic [NUM_REQ-1:0] oh;
    oh          = NUM_REQ'(1) << idx;
    req_op[idx] = op;
    req_valid   = oh;
    #1 check_val("op_ready", req_ready, oh);
    exp_q.push_back(exp_data);
    tick();
    req_valid   = '0;
    unit_result = res;
    #1 check_val("op_unit_op", unit_op, op);
    check_val("op_issue_state", state, S_ISSUE);
    check_val("op_issue_no_rsp", rsp_valid, 0);
    tick();
    unit_result = 32'h0bad_0bad;
    #1 check_val("op_rsp_valid", rsp_valid, oh);
    check_val("op_rsp_data", rsp_data, exp_q.pop_front());
    check_val("op_unit_idle", unit_op, RDCYCLE);
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    #1 check_val("op_rsp_cleared", rsp_valid, 0);
    check_val("op_data_cleared", rsp_data, 0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] oh;

    // reset state, with requests pending while reset is held
    apply_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    #1 check_val("rst_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_unit_op", unit_op, RDCYCLE);
    check_val("rst_state", state, S_IDLE);
    apply_reset();

    // single ops: latency and data path
    run_op(0, RDCYCLE, 32'h0000_1234, 32'h0000_1234);
    run_op(2, RDTIME, 32'hA5A5_0001, 32'hA5A5_0001);

    // round robin with all requesters valid: grants 0,1,2,3,0 every 3 cycles
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) req_op[i] = RDINSTRET;
    req_valid   = 4'hF;
    rsp_ready   = 4'hF;
    unit_result = 32'h0000_00C3;
    for (int k = 0; k < 5; k++) begin
      oh = NUM_REQ'(1) << (k % NUM_REQ);
      #1 check_val($sformatf("rr_ready_%0d", k), req_ready, oh);
      tick();
      tick();
      #1 check_val($sformatf("rr_rsp_%0d", k), rsp_valid, oh);
      check_val($sformatf("rr_data_%0d", k), rsp_data, 32'h0000_00C3);
      if (k == 4) req_valid = '0;
      tick();
    end
    rsp_ready = '0;

    // response held while ready low; other ready bits and new requests ignored
    req_op[2] = RDTIMEH;
    req_valid = 4'b0100;
    #1 check_val("hold_ready", req_ready, 4'b0100);
    tick();
    req_valid   = 4'b0010;
    unit_result = 32'hCAFE_0002;
    #1 check_val("hold_unit_op", unit_op, RDTIMEH);
    check_val("hold_issue_ready", req_ready, 0);
    tick();
    unit_result = 32'h1111_1111;
    rsp_ready   = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1 check_val($sformatf("hold_valid_%0d", k), rsp_valid, 4'b0100);
      check_val($sformatf("hold_data_%0d", k), rsp_data, 32'hCAFE_0002);
      check_val($sformatf("hold_ready_%0d", k), req_ready, 0);
      tick();
    end
    rsp_ready = 4'b0100;
    #1 check_val("hold_hs_valid", rsp_valid, 4'b0100);
    check_val("hold_hs_ready", req_ready, 0);
    tick();
    rsp_ready = '0;
    #1 check_val("hold_after_valid", rsp_valid, 0);
    check_val("hold_next_ready", req_ready, 4'b0010);
    req_valid = '0;
    tick();

`ifdef SYSOP_TRAP_EN
    // trap path: SCALL from req3 held until acknowledged, then zero response
    req_op[3] = SCALL;
    req_valid = 4'b1000;
    #1 check_val("trap_req_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      #1 check_val($sformatf("trap_valid_%0d", k), trap_valid, 1);
      check_val($sformatf("trap_id_%0d", k), trap_id, 3);
      check_val($sformatf("trap_cause_%0d", k), trap_cause, TRAP_SCALL);
      check_val($sformatf("trap_unit_op_%0d", k), unit_op, RDCYCLE);
      check_val($sformatf("trap_no_rsp_%0d", k), rsp_valid, 0);
      tick();
    end
    trap_ack = 1'b1;
    #1 check_val("trap_ack_valid", trap_valid, 1);
    tick();
    trap_ack = 1'b0;
    #1 check_val("trap_cleared", trap_valid, 0);
    check_val("trap_rsp_valid", rsp_valid, 4'b1000);
    check_val("trap_rsp_data", rsp_data, 0);
    check_val("trap_rsp_unit_op", unit_op, RDCYCLE);
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
    #1 check_val("trap_done", rsp_valid, 0);
`else
    // trap ops pass through the unit with data forced to zero
    run_op(1, SBREAK, 'x, 32'h0);
    run_op(3, SCALL, 32'h5555_5555, 32'h0);
`endif

    // reset during RESP drops the response; arbitration restarts at req0
    req_op[1] = RDCYCLEH;
    req_valid = 4'b0010;
    #1 check_val("mid_ready", req_ready, 4'b0010);
    tick();
    req_valid   = '0;
    unit_result = 32'h0000_0077;
    tick();
    #1 check_val("mid_rsp_valid", rsp_valid, 4'b0010);
    rst       = 1'b1;
    req_valid = 4'b0011;
    #1 check_val("mid_rst_valid", rsp_valid, 0);
    check_val("mid_rst_data", rsp_data, 0);
    check_val("mid_rst_ready", req_ready, 0);
    check_val("mid_rst_unit_op", unit_op, RDCYCLE);
    check_val("mid_rst_state", state, S_IDLE);
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check_val($sformatf("mid_no_rsp_%0d", k), rsp_valid, 0);
      tick();
    end
    req_valid = 4'b0011;
    #1 check_val("mid_prio_req0", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    check_val("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysop_scheduler.md
SYSOP_SCHEDULER -- requirements
Module: sysop_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of hardware-thread requesters sharing one system execute unit; legal range 1..16.
REQ-002 SHALL have parameter REQ_ID_W, default $clog2(NUM_REQ) (minimum 1): requester index width.
REQ-003 SHALL have port i_aclk, input, 1: single clock; all logic rises on posedge.
REQ-004 SHALL have port i_areset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port i_req_valid, input, NUM_REQ: per-requester op request.
REQ-006 SHALL have port i_req_op, input, NUM_REQ x t_sysop (packed): per-requester system op.
REQ-007 SHALL have port o_req_ready, output, NUM_REQ: one-hot acceptance.
REQ-008 SHALL have port o_unit_op, output, t_sysop: op driven to the shared system execute unit.
REQ-009 SHALL have port i_unit_result, input, DATA_SIZE: combinational result returned by the unit for o_unit_op.
REQ-010 SHALL have port o_rsp_valid, output, NUM_REQ: one-hot response valid.
REQ-011 SHALL have port o_rsp_data, output, DATA_SIZE: response data shared by all requesters.
REQ-012 SHALL have port i_rsp_ready, input, NUM_REQ: per-requester response accept.
REQ-013 SHALL have ports o_trap_valid (output, 1), o_trap_id (output, REQ_ID_W), o_trap_cause (output, t_trap_cause) and i_trap_ack (input, 1), present only with SYSOP_TRAP_EN.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RESP, and TRAP (TRAP only with SYSOP_TRAP_EN).
REQ-015 IDLE: round-robin arbitration SHALL pick the first valid requester searching from ptr upward, wrapping NUM_REQ-1 to 0; o_req_ready SHALL be one-hot on that index, and all-zero when no request is valid or the FSM is not in IDLE.
REQ-016 On handshake (valid & ready) in cycle t, the FSM SHALL register grant index and op, and set ptr = grant+1 (mod NUM_REQ).
REQ-017 From IDLE after a handshake, the next state SHALL be ISSUE, or TRAP for SCALL/SBREAK when SYSOP_TRAP_EN is defined.
REQ-018 ISSUE (cycle t+1) SHALL drive o_unit_op = granted op and capture i_unit_result into the response register at the end of that cycle; next state RESP.
REQ-019 Outside ISSUE, o_unit_op SHALL be RDCYCLE, and i_unit_result SHALL be ignored.
REQ-020 RESP (from t+2) SHALL set o_rsp_valid[grant]=1 and o_rsp_data stable until i_rsp_ready[grant]; when both are high, next state SHALL be IDLE.
REQ-021 Request-to-response latency SHALL be 2 cycles minimum; at most one op SHALL be in flight; back-to-back throughput SHALL be one op per 3 cycles.
REQ-022 o_rsp_data SHALL be 0 whenever o_rsp_valid is all-zero; SCALL/SBREAK responses SHALL carry data 0, not the unit's x.
REQ-023 i_rsp_ready on non-granted indices SHALL be ignored; i_req_valid changes outside IDLE SHALL have no effect.

Reset
REQ-024 While i_areset is high, the block SHALL force state=IDLE, ptr=0, grant=0, response register=0, and all outputs to 0 except o_unit_op=RDCYCLE.
REQ-025 A reset asserted mid-ISSUE/RESP/TRAP SHALL drop the pending response, with no response after release.
REQ-026 After reset release, the first arbitration cycle SHALL treat index 0 as highest priority.

Configuration
REQ-027 Macro SYSOP_TRAP_EN defined: SCALL/SBREAK SHALL bypass ISSUE and enter TRAP, asserting o_trap_valid with o_trap_id=grant and o_trap_cause=TRAP_SCALL/TRAP_SBREAK; these SHALL be held until i_trap_ack, then the FSM SHALL enter RESP with data 0.
REQ-028 Macro undefined: trap ports SHALL be absent and SCALL/SBREAK SHALL pass through ISSUE like other ops, with response data forced to 0.

Structure
REQ-029 multicore_pkg SHALL hold t_sysop (existing), DATA_SIZE (existing), new enum t_trap_cause {TRAP_SCALL=0, TRAP_SBREAK=1}, and new enum t_sysop_sched_state.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (params NUM_REQ; ports req, ptr, grant_onehot, grant_idx), purely combinational; ptr register stays in sysop_scheduler.

Verification
REQ-031 NUM_REQ=4; req0 RDCYCLE at t with unit returning 0x0000_1234 in ISSUE -> o_req_ready=0001 at t, o_unit_op=RDCYCLE at t+1, o_rsp_valid=0001 with data 0x0000_1234 at t+2.
REQ-032 All four valid continuously, rsp_ready always 1 -> grants 0,1,2,3,0 every 3 cycles; no starvation.
REQ-033 req2 RDTIMEH, i_rsp_ready[2] held low 5 cycles -> o_rsp_valid=0100 and data stable for 5 cycles; new req1 is not readied until the cycle after the handshake.
REQ-034 SYSOP_TRAP_EN defined; req3 SCALL -> o_trap_valid=1, id=3, cause=TRAP_SCALL until i_trap_ack 2 cycles later; then o_rsp_valid=1000, data 0; o_unit_op stays RDCYCLE throughout.
REQ-035 Macro undefined; req1 SBREAK with unit result 'x -> o_rsp_data=0.
REQ-036 i_areset pulsed during RESP of req1 -> all outputs 0 immediately; no response after release; next arbitration favors req0.
